// File: rtl/store_narrower.sv
// Narrows a 32-bit register value to byte/halfword/word and writes it
// little-endian, one byte at a time, to a valid/ready byte-wide memory port.
module store_narrower #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data,
  input  logic [1:0]        size,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              overflow,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITE, DONE} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [1:0]        size_q;
  logic [1:0]        k;
  logic [1:0]        last_k;
  logic              bad;
  logic              ovf;

  // Request properties are derived from the latched copy, so they stay
  // constant for the whole store regardless of what the inputs do.
  always_comb begin
    last_k = 2'd3;
    bad    = 1'b0;
    ovf    = 1'b0;
    case (size_q)
      2'b00: begin
        last_k = 2'd0;
        ovf    = !((&data_q[31:7]) || !(|data_q[31:7]));
      end
      2'b01: begin
        last_k = 2'd1;
        bad    = addr_q[0];
        ovf    = !((&data_q[31:15]) || !(|data_q[31:15]));
      end
      2'b10: begin
        last_k = 2'd3;
        bad    = (addr_q[1:0] != 2'b00);
      end
      default: begin
        last_k = 2'd3;
        bad    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      size_q <= '0;
      k      <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        addr_q <= addr;
        data_q <= data;
        size_q <= size;
      end
      if (state == CHECK)
        k <= '0;
      else if (state == WRITE && mem_ready)
        k <= k + 2'd1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CHECK;
      CHECK:   next_state = bad ? DONE : WRITE;
      WRITE:   if (mem_ready && k == last_k) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Memory outputs are forced to zero outside WRITE so the port is quiet when idle.
  always_comb begin
    busy      = (state == CHECK) || (state == WRITE);
    done      = (state == DONE);
    err       = (state == DONE) && bad;
    overflow  = (state == DONE) && ovf;
    mem_we    = (state == WRITE);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == WRITE) begin
      mem_addr  = addr_q + {{(ADDR_W-2){1'b0}}, k};
      mem_wdata = data_q[{k, 3'b000} +: 8];
    end
  end

endmodule
